// File: rtl/multi_alarm_clock.sv
// -----------------------------------------------------------------------------
// multi_alarm_clock
//
// 24-hour timekeeping core with seconds resolution and NUM_ALARMS independent
// alarm channels. Each channel has its own ringing/snooze state machine.
//
// Build option:
//   ALARM_SNOOZE_EN  - when defined, snooze_btn moves ringing channels into a
//                      SNOOZED state that re-rings after SNOOZE_MINUTES. When
//                      undefined, snooze logic is not built, snooze_btn is
//                      ignored and alarm_snoozed is tied low.
//
// Ports:
//   clk, rst              - single clock, asynchronous active-high reset
//   load_time             - strobe: load new_hours/new_minutes, clear seconds
//   new_hours/new_minutes - time to load (clamped to 23/59)
//   alarm_wr              - strobe: write channel alarm_idx, force it to IDLE
//   alarm_idx             - channel to write
//   alarm_hours/minutes   - alarm time to write
//   alarm_en_in           - enable bit to write
//   snooze_btn, stop_btn  - debounced one-cycle pulses, act on all channels
//   seconds/minutes/hours - current time
//   minute_tick           - one-cycle pulse on each minute boundary
//   alarm_ringing         - per-channel ringing flag
//   alarm_snoozed         - per-channel snoozed flag
//   alarm_any             - OR of alarm_ringing
// -----------------------------------------------------------------------------
module multi_alarm_clock #(
    parameter int TICK_COUNT_MAX = 50000000,
    parameter int NUM_ALARMS     = 4,
    parameter int RING_MINUTES   = 1,
    parameter int SNOOZE_MINUTES = 5,
    localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_time,
    input  logic [4:0]            new_hours,
    input  logic [5:0]            new_minutes,
    input  logic                  alarm_wr,
    input  logic [IW-1:0]         alarm_idx,
    input  logic [4:0]            alarm_hours,
    input  logic [5:0]            alarm_minutes,
    input  logic                  alarm_en_in,
    input  logic                  snooze_btn,
    input  logic                  stop_btn,
    output logic [5:0]            seconds,
    output logic [5:0]            minutes,
    output logic [4:0]            hours,
    output logic                  minute_tick,
    output logic [NUM_ALARMS-1:0] alarm_ringing,
    output logic [NUM_ALARMS-1:0] alarm_snoozed,
    output logic                  alarm_any
);

    localparam int              PW        = $clog2(TICK_COUNT_MAX);
    localparam logic [PW-1:0]   PS_LAST   = PW'(TICK_COUNT_MAX - 1);
    localparam logic [5:0]      RING_LAST = 6'(RING_MINUTES - 1);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_RINGING, ST_SNOOZED} state_t;
    localparam logic [5:0] SNZ_START = 6'(SNOOZE_MINUTES);
`else
    typedef enum logic {ST_IDLE, ST_RINGING} state_t;
`endif

    // Timekeeping state
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hr_q, hr_d;
    logic          tick_q;
    logic          min_evt;

    // Alarm channel state
    state_t     st_q      [NUM_ALARMS];
    state_t     st_d      [NUM_ALARMS];
    logic [4:0] alm_hr_q  [NUM_ALARMS];
    logic [4:0] alm_hr_d  [NUM_ALARMS];
    logic [5:0] alm_min_q [NUM_ALARMS];
    logic [5:0] alm_min_d [NUM_ALARMS];
    logic       alm_en_q  [NUM_ALARMS];
    logic       alm_en_d  [NUM_ALARMS];
    logic [5:0] ring_q    [NUM_ALARMS];
    logic [5:0] ring_d    [NUM_ALARMS];
`ifdef ALARM_SNOOZE_EN
    logic [5:0] snz_q     [NUM_ALARMS];
    logic [5:0] snz_d     [NUM_ALARMS];
`else
    logic       unused_snooze;
    assign unused_snooze = snooze_btn;
`endif

    // Time counters. min_evt is the minute boundary taken on this edge; the
    // alarm FSMs compare against the next-state time so ringing starts on
    // the same edge that minutes takes the matching value.
    always_comb begin
        presc_d = presc_q + PW'(1);
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        min_evt = 1'b0;
        if (load_time) begin
            // A load discards any coincident prescaler wrap.
            presc_d = '0;
            sec_d   = '0;
            hr_d    = (new_hours > 5'd23)   ? 5'd23 : new_hours;
            min_d   = (new_minutes > 6'd59) ? 6'd59 : new_minutes;
        end else if (presc_q == PS_LAST) begin
            presc_d = '0;
            if (sec_q == 6'd59) begin
                sec_d   = '0;
                min_evt = 1'b1;
                if (min_q == 6'd59) begin
                    min_d = '0;
                    hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    // Alarm channel FSMs; a write to a channel overrides its own transition.
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            st_d[i]      = st_q[i];
            alm_hr_d[i]  = alm_hr_q[i];
            alm_min_d[i] = alm_min_q[i];
            alm_en_d[i]  = alm_en_q[i];
            ring_d[i]    = ring_q[i];
`ifdef ALARM_SNOOZE_EN
            snz_d[i]     = snz_q[i];
`endif
            if (alarm_wr && (alarm_idx == IW'(i))) begin
                alm_hr_d[i]  = alarm_hours;
                alm_min_d[i] = alarm_minutes;
                alm_en_d[i]  = alarm_en_in;
                st_d[i]      = ST_IDLE;
            end else begin
                case (st_q[i])
                    ST_IDLE: begin
                        if (alm_en_q[i] && min_evt &&
                            (hr_d == alm_hr_q[i]) && (min_d == alm_min_q[i])) begin
                            st_d[i]   = ST_RINGING;
                            ring_d[i] = '0;
                        end
                    end
                    ST_RINGING: begin
                        if (stop_btn) begin
                            st_d[i] = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
                        end else if (snooze_btn) begin
                            st_d[i]  = ST_SNOOZED;
                            snz_d[i] = SNZ_START;
`endif
                        end else if (min_evt) begin
                            if (ring_q[i] == RING_LAST) begin
                                st_d[i] = ST_IDLE;
                            end else begin
                                ring_d[i] = ring_q[i] + 6'd1;
                            end
                        end
                    end
`ifdef ALARM_SNOOZE_EN
                    ST_SNOOZED: begin
                        if (stop_btn) begin
                            st_d[i] = ST_IDLE;
                        end else if (min_evt) begin
                            if (snz_q[i] <= 6'd1) begin
                                st_d[i]   = ST_RINGING;
                                ring_d[i] = '0;
                            end else begin
                                snz_d[i] = snz_q[i] - 6'd1;
                            end
                        end
                    end
`endif
                    default: st_d[i] = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hr_q    <= '0;
            tick_q  <= 1'b0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                st_q[i]      <= ST_IDLE;
                alm_hr_q[i]  <= '0;
                alm_min_q[i] <= '0;
                alm_en_q[i]  <= 1'b0;
                ring_q[i]    <= '0;
`ifdef ALARM_SNOOZE_EN
                snz_q[i]     <= '0;
`endif
            end
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
            tick_q  <= min_evt;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                st_q[i]      <= st_d[i];
                alm_hr_q[i]  <= alm_hr_d[i];
                alm_min_q[i] <= alm_min_d[i];
                alm_en_q[i]  <= alm_en_d[i];
                ring_q[i]    <= ring_d[i];
`ifdef ALARM_SNOOZE_EN
                snz_q[i]     <= snz_d[i];
`endif
            end
        end
    end

    always_comb begin
        alarm_ringing = '0;
        alarm_snoozed = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            alarm_ringing[i] = (st_q[i] == ST_RINGING);
`ifdef ALARM_SNOOZE_EN
            alarm_snoozed[i] = (st_q[i] == ST_SNOOZED);
`endif
        end
    end

    assign seconds     = sec_q;
    assign minutes     = min_q;
    assign hours       = hr_q;
    assign minute_tick = tick_q;
    assign alarm_any   = |alarm_ringing;

endmodule
